// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants used by the memory-access stage.
// Holds writeback-source encoding, load/store funct3 codes and MEM FSM states.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port bundle: single-outstanding request/accept plus read-data return.
// The pipeline stage is the master; the memory (or a bench model) is the slave.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic for loads and stores: store lane replication and byte enables,
// load extraction with sign/zero extension, and illegal/misaligned access detection.
module lsu_align
    import riscv_pkg::*;
(
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      lane_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            fault_o
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic        badLoadF3;
    logic        badStoreF3;
    logic        misaligned;

    always_comb begin
        wdata_o = store_data_i;
        be_o    = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {4{store_data_i[7:0]}};
                be_o    = 4'b0001 << lane_i;
            end
            2'b01: begin
                wdata_o = {2{store_data_i[15:0]}};
                be_o    = 4'b0011 << lane_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        loadByte = rdata_i[7:0];
        case (lane_i)
            2'd1:    loadByte = rdata_i[15:8];
            2'd2:    loadByte = rdata_i[23:16];
            2'd3:    loadByte = rdata_i[31:24];
            default: loadByte = rdata_i[7:0];
        endcase
        loadHalf = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{loadByte[7]}}, loadByte};
            F3_BU:   load_data_o = {24'd0, loadByte};
            F3_H:    load_data_o = {{16{loadHalf[15]}}, loadHalf};
            F3_HU:   load_data_o = {16'd0, loadHalf};
            default: load_data_o = rdata_i;
        endcase
    end

    // Size comes from funct3[1:0]; an illegal code never reaches the memory, so its
    // alignment rule does not matter.
    always_comb begin
        badLoadF3  = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        badStoreF3 = !(funct3_i inside {F3_B, F3_H, F3_W});
        misaligned = ((funct3_i[1:0] == 2'b01) && lane_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (lane_i != 2'b00));
        fault_o    = (mem_read_i && mem_write_i) ||
                     (mem_read_i && badLoadF3) ||
                     (mem_write_i && badStoreF3) ||
                     ((mem_read_i || mem_write_i) && misaligned);
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the data-memory handshake, stalls upstream while
// an access is in flight, and owns the MEM/WB pipeline register.
module mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid_i,
    input  logic [XLEN-1:0] in_alu_result_i,
    input  logic [XLEN-1:0] in_store_data_i,
    input  logic [XLEN-1:0] in_pc_plus_4_i,
    input  logic [4:0]      in_rd_i,
    input  logic            in_regwrite_i,
    input  logic [1:0]      in_wb_sel_i,
    input  logic            in_mem_read_i,
    input  logic            in_mem_write_i,
    input  logic [2:0]      in_funct3_i,

    output logic            mem_stall_o,

    mem_stage_if.master     dmem,

    output logic            out_valid_o,
    output logic            out_regwrite_o,
    output logic [XLEN-1:0] out_mem_data_o,
    output logic [XLEN-1:0] out_alu_result_o,
    output logic [XLEN-1:0] out_pc_plus_4_o,
    output logic [4:0]      out_rd_o,
    output logic [1:0]      out_wb_sel_o,
    output logic            out_fault_o
);

    mem_state_e      state_q, state_d;

    logic            alignFault;
    logic            memOp;
    logic            fault;
    logic            reqRaw;
    logic            stall;
    logic            loadDone;
    logic [XLEN-1:0] loadData;

    logic            out_valid_q;
    logic            out_regwrite_q;
    logic [XLEN-1:0] out_mem_data_q;
    logic [XLEN-1:0] out_alu_result_q;
    logic [XLEN-1:0] out_pc_plus_4_q;
    logic [4:0]      out_rd_q;
    wb_sel_e         out_wb_sel_q;
    logic            out_fault_q;

    lsu_align u_align (
        .mem_read_i   (in_mem_read_i),
        .mem_write_i  (in_mem_write_i),
        .funct3_i     (in_funct3_i),
        .lane_i       (in_alu_result_i[1:0]),
        .store_data_i (in_store_data_i),
        .rdata_i      (dmem.rdata),
        .wdata_o      (dmem.wdata),
        .be_o         (dmem.be),
        .load_data_o  (loadData),
        .fault_o      (alignFault)
    );

    assign memOp = in_valid_i && (in_mem_read_i || in_mem_write_i);
    assign fault = memOp && alignFault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only loads enter WAIT_RESP; a store is finished once the memory accepts it.
    always_comb begin
        state_d  = state_q;
        reqRaw   = 1'b0;
        stall    = 1'b0;
        loadDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (memOp && !fault) begin
                    reqRaw = 1'b1;
                    if (dmem.ready) begin
                        if (in_mem_read_i) begin
                            stall   = 1'b1;
                            state_d = WAIT_RESP;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                if (dmem.rvalid) begin
                    loadDone = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall_o = stall;
    assign dmem.req    = reqRaw && rst_n;
    assign dmem.we     = in_mem_write_i;
    assign dmem.addr   = {in_alu_result_i[31:2], 2'b00};

    // A stalled cycle inserts a bubble: qualifiers drop, payload fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_regwrite_q   <= 1'b0;
            out_mem_data_q   <= '0;
            out_alu_result_q <= '0;
            out_pc_plus_4_q  <= '0;
            out_rd_q         <= '0;
            out_wb_sel_q     <= WB_ALU;
            out_fault_q      <= 1'b0;
        end else if (stall) begin
            out_valid_q    <= 1'b0;
            out_regwrite_q <= 1'b0;
            out_fault_q    <= 1'b0;
        end else begin
            out_valid_q      <= in_valid_i;
            out_regwrite_q   <= in_valid_i && in_regwrite_i && !fault;
            out_mem_data_q   <= loadDone ? loadData : '0;
            out_alu_result_q <= in_alu_result_i;
            out_pc_plus_4_q  <= in_pc_plus_4_i;
            out_rd_q         <= in_rd_i;
            out_wb_sel_q     <= wb_sel_e'(in_wb_sel_i);
            out_fault_q      <= fault;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_regwrite_o   = out_regwrite_q;
    assign out_mem_data_o   = out_mem_data_q;
    assign out_alu_result_o = out_alu_result_q;
    assign out_pc_plus_4_o  = out_pc_plus_4_q;
    assign out_rd_o         = out_rd_q;
    assign out_wb_sel_o     = out_wb_sel_q;
    assign out_fault_o      = out_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic,
// compared against a byte-level reference model of RV32I load/store semantics.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [31:0] in_pc_plus_4;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic [1:0]  in_wb_sel;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic        mem_stall;
    logic        out_valid;
    logic        out_regwrite;
    logic [31:0] out_mem_data;
    logic [31:0] out_alu_result;
    logic [31:0] out_pc_plus_4;
    logic [4:0]  out_rd;
    logic [1:0]  out_wb_sel;
    logic        out_fault;

    int checks = 0;
    int errors = 0;

    mem_stage_if dbus ();

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid),
        .in_alu_result_i  (in_alu_result),
        .in_store_data_i  (in_store_data),
        .in_pc_plus_4_i   (in_pc_plus_4),
        .in_rd_i          (in_rd),
        .in_regwrite_i    (in_regwrite),
        .in_wb_sel_i      (in_wb_sel),
        .in_mem_read_i    (in_mem_read),
        .in_mem_write_i   (in_mem_write),
        .in_funct3_i      (in_funct3),
        .mem_stall_o      (mem_stall),
        .dmem             (dbus),
        .out_valid_o      (out_valid),
        .out_regwrite_o   (out_regwrite),
        .out_mem_data_o   (out_mem_data),
        .out_alu_result_o (out_alu_result),
        .out_pc_plus_4_o  (out_pc_plus_4),
        .out_rd_o         (out_rd),
        .out_wb_sel_o     (out_wb_sel),
        .out_fault_o      (out_fault)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int accessSize(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic modelFault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        if (!rd && !wr) return 1'b0;
        if (rd && !wr)      legal = (int'(f3) inside {0, 1, 2, 4, 5});
        else if (wr && !rd) legal = (int'(f3) inside {0, 1, 2});
        else                legal = 1'b0;
        return !legal || ((addr % accessSize(f3)) != 0);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> (8 * addr[1:0]);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return 32'($signed(w[15:0]));
            3'd5:    return {16'd0, w[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int lane = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= lane) && (i < lane + accessSize(f3));
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sdata);
        logic [31:0] wd;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t = sdata >> (8 * (i % accessSize(f3)));
            wd[8*i +: 8] = t[7:0];
        end
        return wd;
    endfunction

    // Runs one instruction from issue to commit; called and returns at posedge+1.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic regwr, input int readyDly, input int rvalidDly,
                                 output int stalls, output int accepts);
        logic fault;
        logic committed;
        logic commitNow;
        logic expStall;
        logic expReq;
        int   phase;
        int   cnt;
        logic [31:0] pc4 = $urandom;
        logic [4:0]  rdi = 5'($urandom);
        logic [1:0]  wbs = 2'($urandom_range(0, 2));

        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_funct3 = f3;
        in_alu_result = addr; in_store_data = sdata; in_pc_plus_4 = pc4;
        in_rd = rdi; in_regwrite = regwr; in_wb_sel = wbs;
        fault = modelFault(rd, wr, f3, addr);
        stalls = 0; accepts = 0; phase = 0; cnt = 0; committed = 1'b0;

        for (int cyc = 0; cyc < 64 && !committed; cyc++) begin
            expReq = 1'b0; expStall = 1'b0; commitNow = 1'b0;
            dbus.ready = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = $urandom;
            if (!(rd || wr) || fault) begin
                commitNow = 1'b1;
            end else if (phase == 0) begin
                expReq = 1'b1;
                if (cnt >= readyDly) begin
                    dbus.ready = 1'b1;
                    if (wr) commitNow = 1'b1;
                    else begin expStall = 1'b1; phase = 1; cnt = 0; end
                end else begin
                    expStall = 1'b1; cnt++;
                end
            end else begin
                dbus.ready = 1'($urandom);
                if (cnt >= rvalidDly) begin
                    dbus.rvalid = 1'b1; dbus.rdata = rdata; commitNow = 1'b1;
                end else begin
                    expStall = 1'b1; cnt++;
                end
            end
            #4;
            checkOutput({tag, " stall"}, mem_stall, expStall);
            checkOutput({tag, " req"}, dbus.req, expReq);
            if (dbus.req === 1'b1) begin
                checkOutput({tag, " addr"}, dbus.addr, addr & ~32'd3);
                checkOutput({tag, " we"}, dbus.we, wr);
                if (wr) begin
                    checkOutput({tag, " be"}, dbus.be, modelBe(f3, addr));
                    checkOutput({tag, " wdata"}, dbus.wdata, modelWdata(f3, sdata));
                end
                if (dbus.ready) accepts++;
            end
            if (mem_stall === 1'b1) stalls++;
            #6;
            checkOutput({tag, " valid"}, out_valid, commitNow);
            checkOutput({tag, " fault"}, out_fault, commitNow && fault);
            if (commitNow) begin
                checkOutput({tag, " regwrite"}, out_regwrite, regwr && !fault);
                checkOutput({tag, " memdata"}, out_mem_data,
                            (rd && !wr && !fault) ? modelLoad(f3, addr, rdata) : 32'd0);
                checkOutput({tag, " alu"}, out_alu_result, addr);
                checkOutput({tag, " pc4"}, out_pc_plus_4, pc4);
                checkOutput({tag, " rd"}, out_rd, rdi);
                checkOutput({tag, " wbsel"}, out_wb_sel, wbs);
            end else begin
                checkOutput({tag, " bubble regwrite"}, out_regwrite, 1'b0);
            end
            committed = commitNow;
        end
        checks++;
        assert (committed === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s timeout observed=no-commit expected=commit", tag);
        end
        in_valid = 1'b0; dbus.ready = 1'b0; dbus.rvalid = 1'b0;
    endtask

    // One cycle with no instruction, optionally with a stray rvalid that must be ignored.
    task automatic idleCycle(input string tag, input logic strayRvalid);
        in_valid = 1'b0;
        dbus.ready = 1'b0;
        dbus.rvalid = strayRvalid;
        dbus.rdata = 32'hDEADBEEF;
        #4;
        checkOutput({tag, " idle stall"}, mem_stall, 1'b0);
        checkOutput({tag, " idle req"}, dbus.req, 1'b0);
        #6;
        checkOutput({tag, " idle valid"}, out_valid, 1'b0);
        checkOutput({tag, " idle regwrite"}, out_regwrite, 1'b0);
        checkOutput({tag, " idle fault"}, out_fault, 1'b0);
        checkOutput({tag, " idle memdata"}, out_mem_data, 32'd0);
        dbus.rvalid = 1'b0;
    endtask

    initial begin
        int st;
        int acc;
        int kind;
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] addr;

        rst_n = 1'b0;
        in_valid = 1'b0; in_alu_result = '0; in_store_data = '0; in_pc_plus_4 = '0;
        in_rd = '0; in_regwrite = 1'b0; in_wb_sel = '0;
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = '0;
        dbus.ready = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = '0;

        #12;
        checkOutput("reset valid", out_valid, 1'b0);
        checkOutput("reset regwrite", out_regwrite, 1'b0);
        checkOutput("reset fault", out_fault, 1'b0);
        checkOutput("reset memdata", out_mem_data, 32'd0);
        checkOutput("reset alu", out_alu_result, 32'd0);
        checkOutput("reset req", dbus.req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("ADD", 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 32'h0, 1'b1, 0, 0, st, acc);
        checkOutput("ADD stalls", st, 0);

        applyStimulus("SB", 1'b0, 1'b1, 3'd0, 32'h1003, 32'h123456A5, 32'h0, 1'b0, 0, 0, st, acc);
        checkOutput("SB stalls", st, 0);
        checkOutput("SB accepts", acc, 1);

        applyStimulus("LB", 1'b1, 1'b0, 3'd0, 32'h2002, 32'h0, 32'h0080FF00, 1'b1, 0, 0, st, acc);
        checkOutput("LB data", out_mem_data, 32'hFFFFFF80);
        checkOutput("LB stalls", st, 1);

        applyStimulus("LBU", 1'b1, 1'b0, 3'd4, 32'h2002, 32'h0, 32'h0080FF00, 1'b1, 0, 0, st, acc);
        checkOutput("LBU data", out_mem_data, 32'h00000080);

        applyStimulus("LW slow", 1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 32'hCAFEF00D, 1'b1, 3, 1, st, acc);
        checkOutput("LW slow stalls", st, 5);
        checkOutput("LW slow accepts", acc, 1);

        applyStimulus("LH fault", 1'b1, 1'b0, 3'd1, 32'h3001, 32'h0, 32'h0, 1'b1, 0, 0, st, acc);
        checkOutput("LH fault accepts", acc, 0);
        idleCycle("after fault", 1'b0);

        // Abandon a load mid-flight with an asynchronous reset.
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2;
        in_alu_result = 32'h40; in_regwrite = 1'b1; in_rd = 5'd7; in_pc_plus_4 = 32'h88;
        dbus.ready = 1'b1;
        #4;
        checkOutput("rst req issued", dbus.req, 1'b1);
        #6;
        dbus.ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst valid", out_valid, 1'b0);
        checkOutput("rst regwrite", out_regwrite, 1'b0);
        checkOutput("rst alu", out_alu_result, 32'd0);
        checkOutput("rst pc4", out_pc_plus_4, 32'd0);
        checkOutput("rst rd", out_rd, 5'd0);
        checkOutput("rst req gated", dbus.req, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycle("late rvalid", 1'b1);
        applyStimulus("LW post-rst", 1'b1, 1'b0, 3'd2, 32'h50, 32'h0, 32'h13572468, 1'b1, 0, 0, st, acc);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 2 && kind <= 5) || kind == 9;
            wr = (kind >= 6);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                 (wr ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 0)));
            if (!wr && f3 == 3'd3) f3 = 3'd4;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(accessSize(f3)) - 32'd1);
            applyStimulus("rand", rd, wr, f3, addr, $urandom, $urandom, 1'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 2), st, acc);
            if ($urandom_range(0, 2) == 0) idleCycle("rand gap", 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
